xor_arbiter: RTL

XOR_ARBITER -- requirements
Module: xor_arbiter

---
 rtl/xor_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/xor_arbiter.sv
// Two-requester round-robin arbiter that returns the XOR of the granted
// request's operands through a single valid/ready result channel.
module xor_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic               res_id_q, res_id_d;
  logic [7:0]         done_cnt_q, done_cnt_d;
  logic               grant0, grant1;

  // Grants are the ready signals; they are only issued in IDLE and never
  // while reset is asserted. On contention the side not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst && (state_q == IDLE)) begin
      grant0 = req0_valid && (!req1_valid || last_grant_q);
      grant1 = req1_valid && (!req0_valid || !last_grant_q);
    end
  end

  // NOTE: every variable gets a hold value first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    done_cnt_d   = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d      = RESP;
          last_grant_d = grant1;
          res_id_d     = grant1;
          res_data_d   = grant1 ? (req1_a ^ req1_b) : (req0_a ^ req0_b);
        end
      end
      RESP: begin
        if (res_ready) begin
          state_d    = IDLE;
          done_cnt_d = done_cnt_q + 8'd1;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from values sampled at the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      done_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign res_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign res_data   = res_data_q;
  assign res_id     = res_id_q;
  assign done_cnt   = done_cnt_q;

endmodule
